mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port start  in  1  E-stage multiply/divide-class instruction valid this cycle.
REQ-006 SHALL have port op  in  3  operation code (shared package encoding); sampled only when start=1.
REQ-007 SHALL have port src_a  in  32  forwarded rs value from E stage.
REQ-008 SHALL have port src_b  in  32  forwarded rt value from E stage.
REQ-009 SHALL have port busy  out  1  registered; high while an operation is in flight.
REQ-010 SHALL have port hi  out  32  architectural HI register.
REQ-011 SHALL have port lo  out  32  architectural LO register.

Function
REQ-012 SHALL decode op as: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7 and NONE are no-ops.
REQ-013 SHALL be a two-state machine, IDLE and BUSY; busy=1 exactly in BUSY.
REQ-014 SHALL, in IDLE with start=1 and op in MULT/MULTU/DIV/DIVU at edge k, latch the 64-bit result, load counter with the op's cycle count, enter BUSY.
REQ-015 SHALL hold busy=1 during cycles k+1 .. k+N (N = MULT_CYCLES or DIV_CYCLES), decrementing the counter each edge.
REQ-016 SHALL, at edge k+N, write hi/lo from the latched result and return to IDLE in the same edge.
REQ-017 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned 32x32->64; {hi,lo} = product.
REQ-018 SHALL compute DIV signed: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-019 SHALL compute DIVU unsigned: lo = quotient, hi = remainder.
REQ-020 SHALL, on DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-021 SHALL, on divide by zero (src_b=0), still occupy BUSY for DIV_CYCLES but leave hi/lo unchanged at completion.
REQ-022 SHALL, in IDLE with start=1 and op=MTHI/MTLO, write src_a to hi/lo at that edge with no busy cycle.
REQ-023 SHALL ignore start (any op) while in BUSY; hazard logic guarantees it does not occur, but state SHALL be unaffected.
REQ-024 SHALL keep hi/lo stable except at the edges defined in REQ-016 and REQ-022, so mfhi/mflo read them directly.

Reset
REQ-025 SHALL, when reset=1 at an edge, set hi=0, lo=0, busy=0, counter=0, state=IDLE, discarding any in-flight result.
REQ-026 SHALL give reset priority over start and over a completion at the same edge.

Structure
REQ-027 SHALL take op encodings and default cycle counts from the shared constants package used by the pipeline registers and control unit.
REQ-028 SHALL contain at most one sub-module, mdu_arith, purely combinational, producing the 64-bit {hi,lo} result for op/src_a/src_b.
REQ-029 SHALL keep counter width sufficient for max(MULT_CYCLES, DIV_CYCLES).

Verification
REQ-030 SHALL test MULT src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 SHALL test MULTU src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 SHALL test DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL test MTHI 0x12345678 then DIVU 7/0 -> hi=0x12345678 immediately and unchanged after 10 busy cycles; lo unchanged.
REQ-034 SHALL test MTLO 0xAAAA5555 issued during DIV cycle 4 -> ignored; lo equals DIV quotient after completion.
REQ-035 SHALL test reset at DIV cycle 3 -> next cycle busy=0, hi=0, lo=0; no later writeback occurs.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared constants for the multiply/divide unit: operation
//               encodings, default latencies and the unit's state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

  // Operation codes carried down the pipeline for multiply/divide-class ops
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  // Default number of busy cycles for each long-latency class
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Control state of the unit
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational datapath producing the 64-bit {hi,lo} result
//               of a multiply or divide for the given op and operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result
);

  // Signedness of the selected operation
  logic w_signed_mul;
  logic w_signed_div;

  // Multiplier operands widened to 64 bits so one product serves both forms
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_product;

  // Divider works on magnitudes; sign fix-up is applied afterwards
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_quot_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed_mul = (mdu_op_e'(op) == OP_MULT);
  assign w_signed_div = (mdu_op_e'(op) == OP_DIV);

  assign w_mul_a   = {{32{w_signed_mul & src_a[31]}}, src_a};
  assign w_mul_b   = {{32{w_signed_mul & src_b[31]}}, src_b};
  assign w_product = w_mul_a * w_mul_b;

  assign w_a_neg = w_signed_div & src_a[31];
  assign w_b_neg = w_signed_div & src_b[31];
  assign w_mag_a = w_a_neg ? (~src_a + 32'd1) : src_a;
  assign w_mag_b = w_b_neg ? (~src_b + 32'd1) : src_b;

  // A zero divisor is replaced by one purely to keep the datapath defined;
  // the top discards the result in that case.
  assign w_divisor  = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_quot_mag = w_mag_a / w_divisor;
  assign w_rem_mag  = w_mag_a % w_divisor;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign w_quot = (w_a_neg ^ w_b_neg) ? (~w_quot_mag + 32'd1) : w_quot_mag;
  assign w_rem  = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

  // Select the product or {remainder, quotient} according to the op
  always_comb begin
    result = 64'd0;
    case (mdu_op_e'(op))
      OP_MULT, OP_MULTU: result = w_product;
      OP_DIV, OP_DIVU:   result = {w_rem, w_quot};
      default:           result = 64'd0;
    endcase
  end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle multiply/divide unit owning the architectural
//               HI/LO registers. The result is computed when the op is
//               accepted and committed to HI/LO after the op's latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int C_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

  mdu_state_e         state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q,   cnt_d;
  logic [63:0]        res_q,   res_d;
  logic               wr_q,    wr_d;
  logic [31:0]        hi_q,    hi_d;
  logic [31:0]        lo_q,    lo_d;

  logic [63:0]        w_result;

  mdu_arith u_arith (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (w_result)
  );

  // Next-state logic: accept ops in IDLE, count down and commit in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          case (mdu_op_e'(op))
            OP_MULT, OP_MULTU: begin
              res_d   = w_result;
              wr_d    = 1'b1;
              cnt_d   = C_CNT_W'(MULT_CYCLES);
              state_d = MDU_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still takes the full latency but commits nothing
              res_d   = w_result;
              wr_d    = (src_b != 32'd0);
              cnt_d   = C_CNT_W'(DIV_CYCLES);
              state_d = MDU_BUSY;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      MDU_BUSY: begin
        // New starts are ignored here; hazard logic keeps them away anyway
        cnt_d = cnt_q - C_CNT_W'(1);
        if (cnt_q <= C_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = MDU_IDLE;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // State registers; reset wins over any start or completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MDU_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;
  int n_busy;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op for a single edge; returns at the negedge after that edge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
  endtask

  // Count busy cycles until the unit returns to idle (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = OP_NONE;
    src_a   = 32'd0;
    src_b   = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
    check("mult_hi_during", hi, 32'h0);
    wait_done(n_busy);
    check("mult_cycles", n_busy, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    check("multu_lo_during", lo, 32'hFFFFFFFE);
    wait_done(n_busy);
    check("multu_cycles", n_busy, 32'd5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n_busy);
    check("div_cycles", n_busy, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(OP_MTHI, 32'h12345678, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'hFFFFFFFD);

    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(n_busy);
    check("divz_cycles", n_busy, 32'd10);
    check("divz_hi", hi, 32'h12345678);
    check("divz_lo", lo, 32'hFFFFFFFD);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n_busy);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h0);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(n_busy);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done(n_busy);
    check("divneg_lo", lo, 32'hFFFFFFFD);
    check("divneg_hi", hi, 32'd1);

    issue(OP_MULT, 32'hFFFFFFF9, 32'hFFFFFFFD);
    wait_done(n_busy);
    check("multneg_hi", hi, 32'h0);
    check("multneg_lo", lo, 32'd21);

    issue(OP_MTLO, 32'hABCD0123, 32'd0);
    check("mtlo_lo", lo, 32'hABCD0123);
    check("mtlo_hi", hi, 32'h0);

    // MTLO arriving during busy cycle 4 of a DIV must be dropped
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = OP_MTLO;
    src_a = 32'hAAAA5555;
    @(negedge clk);
    start = 1'b0;
    op    = OP_NONE;
    check("mtlo_ign_lo_during", lo, 32'hABCD0123);
    check("mtlo_ign_busy", {31'd0, busy}, 32'd1);
    wait_done(n_busy);
    check("mtlo_ign_rest_cycles", n_busy, 32'd6);
    check("mtlo_ign_lo", lo, 32'hFFFFFFF2);
    check("mtlo_ign_hi", hi, 32'd2);

    // Reset during busy cycle 3 of a DIV discards the pending result
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    repeat (12) @(negedge clk);
    check("rst_late_busy", {31'd0, busy}, 32'd0);
    check("rst_late_hi", hi, 32'h0);
    check("rst_late_lo", lo, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mult_div_unit
`default_nettype wire
